// File: rtl/crossbar_pkg.sv
// Shared types and width helper for the stream crossbar arbitration block.
package crossbar_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int max1_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/crossbar_arbiter_array_if.sv
// Handshake bundle between the crossbar sources/destinations and the arbiter array.
interface crossbar_arbiter_array_if #(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3
);
  import crossbar_pkg::*;

  localparam int T_ID___WIDTH = max1_clog2(S_DATA_COUNT);
  localparam int T_DEST_WIDTH = max1_clog2(M_DATA_COUNT);

  logic [S_DATA_COUNT-1:0]                   s_valid_i;
  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i;
  logic [S_DATA_COUNT-1:0]                   s_last_i;
  logic [S_DATA_COUNT-1:0]                   s_ready_o;
  logic [S_DATA_COUNT-1:0]                   s_dest_err_o;
  logic [M_DATA_COUNT-1:0]                   m_ready_i;
  logic [M_DATA_COUNT-1:0]                   m_valid_o;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_id_o;
  logic [M_DATA_COUNT-1:0]                   grant_valid_o;

  // Arbiter side.
  modport slave (
    input  s_valid_i, s_dest_i, s_last_i, m_ready_i,
    output s_ready_o, s_dest_err_o, m_valid_o, grant_id_o, grant_valid_o
  );

  // Source/destination environment side.
  modport master (
    output s_valid_i, s_dest_i, s_last_i, m_ready_i,
    input  s_ready_o, s_dest_err_o, m_valid_o, grant_id_o, grant_valid_o
  );

endinterface

// File: rtl/crossbar_arbiter_array_packet_lock_arbiter.sv
// One destination's arbiter: picks a source, then holds it until the last beat transfers.
module packet_lock_arbiter
  import crossbar_pkg::*;
#(
  parameter int        N        = 2,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  parameter int        IDW      = max1_clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic           src_valid_i,
  input  logic           src_last_i,
  input  logic           m_ready_i,
  output logic [IDW-1:0] grant_id_o,
  output logic           locked_o
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] winner_s;
  logic           found_s;

  // Winner search: rotate from the pointer in round-robin, from index 0 in fixed mode.
  always_comb begin
    int  idx;
    logic take;
    winner_s = '0;
    found_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx      = (ARB_MODE == ARB_RR) ? (int'(ptr_q) + i) : i;
      idx      = (idx >= N) ? (idx - N) : idx;
      take     = ~found_s & req_i[idx];
      winner_s = take ? IDW'(idx) : winner_s;
      found_s  = found_s | take;
    end
  end

  // Next-state logic; the pointer advances only when a packet ends.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    case (state_q)
      ARB_IDLE: begin
        if (found_s) begin
          state_d    = ARB_LOCKED;
          grant_id_d = winner_s;
        end else begin
          state_d    = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (src_valid_i && m_ready_i && src_last_i) begin
          state_d = ARB_IDLE;
          if (ARB_MODE == ARB_RR) begin
            ptr_d = (grant_id_q == IDW'(N - 1)) ? IDW'(0) : (grant_id_q + IDW'(1));
          end else begin
            ptr_d = ptr_q;
          end
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign grant_id_o = grant_id_q;
  assign locked_o   = (state_q == ARB_LOCKED);

endmodule

// File: rtl/crossbar_arbiter_array.sv
// Per-destination packet-locked arbitration and handshake fan-in/fan-out for the stream crossbar.
module crossbar_arbiter_array
  import crossbar_pkg::*;
#(
  parameter int        S_DATA_COUNT = 2,
  parameter int        M_DATA_COUNT = 3,
  parameter arb_mode_e ARB_MODE     = ARB_RR
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  crossbar_arbiter_array_if.slave  bus
);

  localparam int T_ID___WIDTH = max1_clog2(S_DATA_COUNT);
  localparam int T_DEST_WIDTH = max1_clog2(M_DATA_COUNT);

  logic [S_DATA_COUNT-1:0] req_s [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] grant_id_s [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] locked_s;
  logic [M_DATA_COUNT-1:0] src_valid_s;
  logic [M_DATA_COUNT-1:0] src_last_s;
  logic [S_DATA_COUNT-1:0] locked_any_s;
  logic [S_DATA_COUNT-1:0] s_ready_s;

  // Sources already held by some destination are masked out of every request vector.
  always_comb begin
    locked_any_s = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      for (int j = 0; j < S_DATA_COUNT; j++) begin
        locked_any_s[j] = locked_any_s[j] |
                          (locked_s[m] & (grant_id_s[m] == T_ID___WIDTH'(j)));
      end
    end
  end

  // Request masks and out-of-range destination flags.
  always_comb begin
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      req_s[m] = '0;
      for (int j = 0; j < S_DATA_COUNT; j++) begin
        req_s[m][j] = bus.s_valid_i[j] & ~locked_any_s[j] &
                      (bus.s_dest_i[j] == T_DEST_WIDTH'(m));
      end
    end
    for (int j = 0; j < S_DATA_COUNT; j++) begin
      bus.s_dest_err_o[j] = bus.s_valid_i[j] & (32'(bus.s_dest_i[j]) >= 32'(M_DATA_COUNT));
    end
  end

  // Granted source's valid/last routed to each destination, ready routed back.
  always_comb begin
    s_ready_s = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      src_valid_s[m] = 1'b0;
      src_last_s[m]  = 1'b0;
      for (int j = 0; j < S_DATA_COUNT; j++) begin
        src_valid_s[m] = src_valid_s[m] | (bus.s_valid_i[j] & (grant_id_s[m] == T_ID___WIDTH'(j)));
        src_last_s[m]  = src_last_s[m]  | (bus.s_last_i[j]  & (grant_id_s[m] == T_ID___WIDTH'(j)));
        s_ready_s[j]   = s_ready_s[j] |
                         (locked_s[m] & bus.m_ready_i[m] & (grant_id_s[m] == T_ID___WIDTH'(j)));
      end
    end
  end

  for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_dest
    packet_lock_arbiter #(
      .N        (S_DATA_COUNT),
      .ARB_MODE (ARB_MODE),
      .IDW      (T_ID___WIDTH)
    ) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_s[m]),
      .src_valid_i (src_valid_s[m]),
      .src_last_i  (src_last_s[m]),
      .m_ready_i   (bus.m_ready_i[m]),
      .grant_id_o  (grant_id_s[m]),
      .locked_o    (locked_s[m])
    );

    assign bus.grant_id_o[m] = grant_id_s[m];
  end

  // Handshakes are suppressed while reset is asserted so no beat slips through a discarded lock.
  assign bus.s_ready_o     = rst_i ? '0 : s_ready_s;
  assign bus.m_valid_o     = rst_i ? '0 : (locked_s & src_valid_s);
  assign bus.grant_valid_o = rst_i ? '0 : locked_s;

endmodule

// File: tb/tb_crossbar_arbiter_array.sv
// Randomized bench: a round-robin and a fixed-priority arbiter array checked against a packet-level model.
module tb_crossbar_arbiter_array;
  import crossbar_pkg::*;

  localparam int S  = 2;
  localparam int M  = 3;
  localparam int DW = 2;
  localparam int IW = 1;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crossbar_arbiter_array_if #(.S_DATA_COUNT(S), .M_DATA_COUNT(M)) bus_rr ();
  crossbar_arbiter_array_if #(.S_DATA_COUNT(S), .M_DATA_COUNT(M)) bus_fx ();

  crossbar_arbiter_array #(.S_DATA_COUNT(S), .M_DATA_COUNT(M), .ARB_MODE(ARB_RR)) dut_rr (
    .clk_i (clk), .rst_i (rst), .bus (bus_rr)
  );
  crossbar_arbiter_array #(.S_DATA_COUNT(S), .M_DATA_COUNT(M), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk_i (clk), .rst_i (rst), .bus (bus_fx)
  );

  logic [S-1:0]         sv [NI];
  logic [S-1:0]         sl [NI];
  logic [S-1:0][DW-1:0] sd [NI];
  logic [M-1:0]         mr;

  logic [S-1:0]         o_srdy [NI];
  logic [S-1:0]         o_derr [NI];
  logic [M-1:0]         o_mv   [NI];
  logic [M-1:0]         o_gv   [NI];
  logic [M-1:0][IW-1:0] o_gid  [NI];

  assign bus_rr.s_valid_i = sv[0];
  assign bus_rr.s_last_i  = sl[0];
  assign bus_rr.s_dest_i  = sd[0];
  assign bus_rr.m_ready_i = mr;
  assign bus_fx.s_valid_i = sv[1];
  assign bus_fx.s_last_i  = sl[1];
  assign bus_fx.s_dest_i  = sd[1];
  assign bus_fx.m_ready_i = mr;

  assign o_srdy[0] = bus_rr.s_ready_o;
  assign o_derr[0] = bus_rr.s_dest_err_o;
  assign o_mv[0]   = bus_rr.m_valid_o;
  assign o_gv[0]   = bus_rr.grant_valid_o;
  assign o_gid[0]  = bus_rr.grant_id_o;
  assign o_srdy[1] = bus_fx.s_ready_o;
  assign o_derr[1] = bus_fx.s_dest_err_o;
  assign o_mv[1]   = bus_fx.m_valid_o;
  assign o_gv[1]   = bus_fx.grant_valid_o;
  assign o_gid[1]  = bus_fx.grant_id_o;

  // Reference model: owning source per destination (-1 = idle), RR pointer, last granted id.
  int owner [NI][M];
  int ptr   [NI][M];
  int gid   [NI][M];
  // Source generators: packet in flight, its destination, beats left, cycles alive.
  int act   [NI][S];
  int pdest [NI][S];
  int left  [NI][S];
  int age   [NI][S];

  int vectors = 0;
  int miscompares = 0;
  int start_pct, gap_pct, rst_pm, force_dest, rst_force;
  int rdy_pct [M];
  int phase_fixed = 0;
  int starve_cnt = 0;
  int rr_src1_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic start_pkt(input int k, input int j, input int d, input int len);
    act[k][j]   = 1;
    pdest[k][j] = d;
    left[k][j]  = len;
    age[k][j]   = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < S; j++) begin
        if (act[k][j] == 0 && $urandom_range(99, 0) < start_pct) begin
          start_pkt(k, j,
                    (force_dest >= 0) ? force_dest :
                    (($urandom_range(9, 0) == 0) ? 3 : int'($urandom_range(M - 1, 0))),
                    int'($urandom_range(4, 1)));
        end
        sv[k][j] = (act[k][j] != 0) && ($urandom_range(99, 0) >= gap_pct);
        sd[k][j] = (act[k][j] != 0) ? DW'(pdest[k][j]) : DW'($urandom_range(M - 1, 0));
        sl[k][j] = (act[k][j] != 0) && (left[k][j] == 1);
      end
    end
    for (int m = 0; m < M; m++) mr[m] = ($urandom_range(99, 0) < rdy_pct[m]);
    rst = (rst_force != 0) || ($urandom_range(999, 0) < rst_pm);
  endtask

  task automatic evaluate();
    for (int k = 0; k < NI; k++) begin
      string tag;
      logic [S-1:0] e_rdy, e_derr, xf;
      logic [M-1:0] e_mv, e_gv;
      logic [M-1:0][IW-1:0] e_gid;
      int held [S];
      int c, cand, o;
      tag = (k == 0) ? "rr" : "fx";
      e_rdy = '0; e_mv = '0; e_gv = '0;
      for (int j = 0; j < S; j++) begin
        e_derr[j] = sv[k][j] && (int'(sd[k][j]) >= M);
        held[j]   = 0;
      end
      for (int m = 0; m < M; m++) begin
        e_gid[m] = IW'(gid[k][m]);
        o = owner[k][m];
        if (o >= 0) held[o] = 1;
        if (!rst && o >= 0) begin
          e_gv[m] = 1'b1;
          e_mv[m] = sv[k][o];
          if (mr[m]) e_rdy[o] = 1'b1;
        end
      end
      check_eq({tag, ".s_ready"},     32'(o_srdy[k]), 32'(e_rdy));
      check_eq({tag, ".s_dest_err"},  32'(o_derr[k]), 32'(e_derr));
      check_eq({tag, ".m_valid"},     32'(o_mv[k]),   32'(e_mv));
      check_eq({tag, ".grant_valid"}, 32'(o_gv[k]),   32'(e_gv));
      check_eq({tag, ".grant_id"},    32'(o_gid[k]),  32'(e_gid));
      if (phase_fixed != 0 && o_gv[k][1] && o_gid[k][1] == IW'(1)) begin
        if (k == 1) starve_cnt++;
        else rr_src1_cnt++;
      end
      xf = sv[k] & e_rdy;
      for (int m = 0; m < M; m++) begin
        if (rst) begin
          owner[k][m] = -1; ptr[k][m] = 0; gid[k][m] = 0;
        end else if (owner[k][m] >= 0) begin
          o = owner[k][m];
          if (xf[o] && sl[k][o]) begin
            ptr[k][m]   = (o + 1) % S;
            owner[k][m] = -1;
          end
        end else begin
          c = -1;
          for (int i = 0; i < S; i++) begin
            cand = (k == 0) ? (ptr[k][m] + i) % S : i;
            if (c < 0 && sv[k][cand] && int'(sd[k][cand]) == m && held[cand] == 0) c = cand;
          end
          if (c >= 0) begin
            owner[k][m] = c; gid[k][m] = c;
          end
        end
      end
      for (int j = 0; j < S; j++) begin
        if (act[k][j] != 0) begin
          age[k][j]++;
          if (xf[j]) begin
            left[k][j]--;
            if (left[k][j] == 0) act[k][j] = 0;
          end else if (pdest[k][j] >= M && age[k][j] > 20) begin
            act[k][j] = 0;
          end
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      @(negedge clk);
      evaluate();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_quiet();
    start_pct = 0; gap_pct = 0; rst_pm = 0; force_dest = -1; rst_force = 0;
    for (int m = 0; m < M; m++) rdy_pct[m] = 100;
  endtask

  task automatic drain();
    int busy;
    set_quiet();
    busy = 1;
    for (int n = 0; n < 80 && busy != 0; n++) begin
      run(1);
      busy = 0;
      for (int k = 0; k < NI; k++) begin
        for (int j = 0; j < S; j++) busy += act[k][j];
        for (int m = 0; m < M; m++) busy += (owner[k][m] >= 0) ? 1 : 0;
      end
    end
    check_eq("drain_timeout", 32'(busy), 32'd0);
    run(1);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int m = 0; m < M; m++) begin owner[k][m] = -1; ptr[k][m] = 0; gid[k][m] = 0; end
      for (int j = 0; j < S; j++) begin act[k][j] = 0; pdest[k][j] = 0; left[k][j] = 0; age[k][j] = 0; end
    end
    set_quiet();
    rst_force = 1;
    run(3);
    rst_force = 0;
    run(1);

    // Two sources contend for destination 1, then source 0 alone, then both again.
    for (int k = 0; k < NI; k++) begin start_pkt(k, 0, 1, 3); start_pkt(k, 1, 1, 3); end
    run(10);
    for (int k = 0; k < NI; k++) start_pkt(k, 0, 1, 3);
    run(6);
    for (int k = 0; k < NI; k++) begin start_pkt(k, 0, 1, 3); start_pkt(k, 1, 1, 3); end
    run(10);

    // Both sources keep requesting destination 1.
    drain();
    force_dest = 1; start_pct = 100; phase_fixed = 1;
    run(40);
    phase_fixed = 0;
    check_eq("fx.src1_starved", 32'(starve_cnt), 32'd0);
    check_eq("rr.src1_served", 32'(rr_src1_cnt > 0), 32'd1);

    // Independent traffic to destinations 0 and 2 with ready toggling on 2.
    drain();
    rdy_pct[2] = 50;
    for (int k = 0; k < NI; k++) begin start_pkt(k, 0, 0, 4); start_pkt(k, 1, 2, 4); end
    run(15);

    // Out-of-range destination stalls with the error flag raised.
    drain();
    for (int k = 0; k < NI; k++) start_pkt(k, 0, 3, 2);
    run(5);

    // Reset on the second beat of a four-beat packet.
    drain();
    for (int k = 0; k < NI; k++) start_pkt(k, 0, 1, 4);
    run(2);
    rst_force = 1;
    run(1);
    rst_force = 0;
    run(8);

    // Backpressure for two cycles, then a valid gap, inside one packet.
    drain();
    for (int k = 0; k < NI; k++) start_pkt(k, 0, 1, 3);
    run(2);
    rdy_pct[1] = 0;
    run(2);
    rdy_pct[1] = 100; gap_pct = 100;
    run(1);
    gap_pct = 0;
    run(5);

    // Random traffic with occasional resets.
    drain();
    for (int r = 0; r < 15; r++) begin
      start_pct = int'($urandom_range(90, 10));
      gap_pct   = int'($urandom_range(50, 0));
      rst_pm    = 5;
      for (int m = 0; m < M; m++) rdy_pct[m] = int'($urandom_range(100, 20));
      run(200);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crossbar_arbiter_array.md
# crossbar_arbiter_array

Per-destination packet arbitration and handshake control for the stream crossbar, successor to the signals control unit. It arbitrates valid-qualified requests from S_DATA_COUNT sources to M_DATA_COUNT destinations and locks each grant for a whole packet, ending at the `last` handshake. It generates `m_valid_o`/`s_ready_o` for the datapath mux and flags out-of-range destinations. Each destination's arbitration mode (round-robin or fixed priority) is set by parameter.

## Interface
- S_DATA_COUNT, 2, number of source (slave-side) ports, ≥1
- M_DATA_COUNT, 3, number of destination (master-side) ports, ≥1
- ARB_MODE, ARB_RR, arbitration mode for every destination: ARB_RR or ARB_FIXED (lowest index wins)
- T_ID___WIDTH, localparam, max(1, $clog2(S_DATA_COUNT))
- T_DEST_WIDTH, localparam, max(1, $clog2(M_DATA_COUNT))
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- s_valid_i  in  S_DATA_COUNT  source beat valid
- s_dest_i  in  [S_DATA_COUNT] × T_DEST_WIDTH  source destination index, stable for a whole packet
- s_last_i  in  S_DATA_COUNT  last beat of packet
- s_ready_o  out  S_DATA_COUNT  source beat accepted
- s_dest_err_o  out  S_DATA_COUNT  s_valid_i & (s_dest_i ≥ M_DATA_COUNT); combinational
- m_ready_i  in  M_DATA_COUNT  destination ready
- m_valid_o  out  M_DATA_COUNT  destination beat valid
- grant_id_o  out  [M_DATA_COUNT] × T_ID___WIDTH  selected source per destination (datapath mux select)
- grant_valid_o  out  M_DATA_COUNT  destination is in LOCKED

## Operation
- Request mask per destination m: req[m][j] = s_valid_i[j] & (s_dest_i[j] == m) & ~locked_any[j].
  - locked_any[j] is set when any destination holds j in LOCKED, so a source is never granted twice.
- Each destination runs an independent FSM with two states.
- IDLE:
  - m_valid_o = 0, grant_valid_o = 0.
  - If req[m] ≠ 0, register the winner into grant_id and go to LOCKED.
- LOCKED:
  - m_valid_o[m] = s_valid_i[grant_id].
  - s_ready_o[grant_id] = m_ready_i[m].
  - A beat transfers when s_valid_i[grant_id] & m_ready_i[m].
  - A transfer with s_last_i[grant_id] = 1 returns the FSM to IDLE.
- ARB_RR:
  - Per-destination pointer ptr. Winner is the first set bit of req at index ≥ ptr, wrapping to index 0.
  - When a packet ends, ptr ← grant_id+1, wrapping at S_DATA_COUNT.
- ARB_FIXED: winner is the lowest set index. No pointer.
- s_ready_o[j] is 0 unless source j is locked by some destination.
- Out-of-range destination: the request matches no destination. s_ready_o stays 0 and s_dest_err_o stays high while valid (the source stalls; upstream handles it).
- Source drops s_valid_i mid-packet: the lock holds and m_valid_o follows s_valid_i.
- S_DATA_COUNT = 1: grant_id is constant 0 and the pointer logic reduces away.

## Timing
- Arbitration latency: a request in IDLE at cycle n → LOCKED and grant_id valid at n+1. The earliest beat transfer is at n+1.
- A packet ending at cycle k → IDLE at k+1 → next grant at k+2. This gives exactly one dead cycle between packets on a destination.
- Single-beat packet (last on the first beat): LOCKED for one cycle.
- s_ready_o and m_valid_o are combinational from state, s_valid_i and m_ready_i; there is no registered data path.
- Reset: on the clock edge with rst_i = 1, all FSMs → IDLE, ptr → 0, grant_id → 0.
  - While rst_i is high, s_ready_o, m_valid_o and grant_valid_o are forced to 0.
  - Reset mid-packet discards the lock; no beat is accepted in that cycle.
- Simultaneous end of packet on m and a new request for m: the new request is ignored until IDLE; the pointer update takes priority.

## Structure
- Package crossbar_pkg:
  - arb_mode_e {ARB_RR, ARB_FIXED}
  - arb_state_e {ARB_IDLE, ARB_LOCKED}
  - max1_clog2 width helper function
- Sub-module packet_lock_arbiter (one per destination). It holds the FSM, pointer and grant_id register.
  - Inputs: req mask, the granted source's valid/last, m_ready.
  - Outputs: grant_id, locked.
- The top level owns the request-mask build, the locked_any OR-reduction, and the s_ready_o/m_valid_o fan-in/fan-out.

## Test plan
- S=2, M=3, RR. Sources 0 and 1 both send 3-beat packets to dest 1 with m_ready = 1.
  - Expect grant 0 at cycle 1, beats at cycles 1–3, IDLE at 4, grant 1 at 5, beats at 5–7.
  - Repeat with source 0 first again: ptr makes source 1 win next.
- Same setup with ARB_FIXED: source 0 is continuously requesting and source 1 is also requesting. Expect source 1 never granted.
- Parallel traffic: source 0 → dest 0 and source 1 → dest 2, simultaneously. Expect both locked at cycle 1 with independent handshakes. m_ready_i[2] toggling stalls only source 1.
- Out-of-range destination: s_dest_i[0] = 3 with M = 3 and valid high.
  - Expect s_dest_err_o[0] = 1, s_ready_o[0] = 0, and all m_valid_o = 0.
- Reset mid-packet: assert rst_i on the second beat of a 4-beat packet.
  - Expect s_ready_o = 0 in that cycle and IDLE afterwards.
  - After release, the same source is re-granted from ptr = 0 within 1 cycle.
- Backpressure plus s_valid_i gaps: m_ready low for 2 cycles and then valid low for 1 cycle within a packet.
  - Expect the lock held, no transfer counted, and release only on the valid & ready & last beat.
